// File: rtl/riscv_pkg.sv
// Shared constants and types for the memory port arbiter.
// Contents: arbiter state encoding, default STARVE_MAX / TIMEOUT,
// the read value returned on a timed-out access, and the memory request payload.
package riscv_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 15;
  localparam int unsigned STARVE_W       = 3;

  // Word returned to the requester when the memory never acknowledges.
  localparam logic [XLEN-1:0] ERR_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_IF_BUSY = 2'd1,
    ARB_DM_BUSY = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_e;

  // Request presented to the single-port memory while a grant is active.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (async active-low), clr (clear, wins over en),
//        en (count enable), count (current value, stops at LIMIT).
module sat_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != WIDTH'(LIMIT))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Data has priority unless fetch has waited through STARVE_MAX data grants.
// A grant that sees no mem_ack within TIMEOUT busy cycles is aborted with
// ERR_RDATA and sets the sticky err flag.
// Ports: clk, reset (async active-low);
//        fetch: if_req, if_addr -> if_rdata, if_ready;
//        data:  dm_rd, dm_wr, dm_addr, dm_wdata -> dm_rdata, dm_ready;
//        memory: mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack;
//        status: stall_if, stall_dm, err.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ready,
  input  logic            dm_rd,
  input  logic            dm_wr,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_ready,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic            stall_if,
  output logic            stall_dm,
  output logic            err
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  arb_state_e state_q, state_d;
  mem_req_t   req_q, req_d;

  logic            en_d, if_ready_d, dm_ready_d, err_d;
  logic [XLEN-1:0] if_rdata_d, dm_rdata_d;

  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic dm_req, busy, starve_full, timeout_hit, done, grant_dm, grant_if;

  assign dm_req      = dm_rd | dm_wr;
  assign busy        = (state_q == ARB_IF_BUSY) || (state_q == ARB_DM_BUSY);
  assign starve_full = (starve_cnt == STARVE_W'(STARVE_MAX));
  // The last allowed busy cycle is the one where the counter reads TIMEOUT-1.
  assign timeout_hit = busy && !mem_ack && (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign done        = busy && (mem_ack || timeout_hit);
  assign grant_dm    = (state_q == ARB_IDLE) && (state_d == ARB_DM_BUSY);
  assign grant_if    = (state_q == ARB_IDLE) && (state_d == ARB_IF_BUSY);

  assign stall_if = if_req & ~if_ready;
  assign stall_dm = dm_req & ~dm_ready;

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;

  // Data grants taken while fetch is waiting.
  sat_counter #(.WIDTH(STARVE_W), .LIMIT(STARVE_MAX)) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (grant_if),
    .en    (grant_dm & if_req),
    .count (starve_cnt)
  );

  // Busy cycles of the current grant.
  sat_counter #(.WIDTH(WAIT_W), .LIMIT(TIMEOUT)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!busy),
    .en    (busy),
    .count (wait_cnt)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      req_q    <= '0;
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      mem_en   <= en_d;
      if_ready <= if_ready_d;
      dm_ready <= dm_ready_d;
      if_rdata <= if_rdata_d;
      dm_rdata <= dm_rdata_d;
      err      <= err_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (dm_req && !(starve_full && if_req)) begin
          state_d = ARB_DM_BUSY;
        end else if (if_req) begin
          state_d = ARB_IF_BUSY;
        end
      end
      ARB_IF_BUSY, ARB_DM_BUSY: begin
        if (done) begin
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Next values of the memory request, response data, ready pulses and err.
  always_comb begin
    req_d      = req_q;
    en_d       = mem_en;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    if_rdata_d = if_rdata;
    dm_rdata_d = dm_rdata;
    err_d      = err;

    if (grant_dm) begin
      // rd and wr together is a write.
      req_d.we    = dm_wr;
      req_d.addr  = dm_addr;
      req_d.wdata = dm_wdata;
      en_d        = 1'b1;
    end else if (grant_if) begin
      req_d.we    = 1'b0;
      req_d.addr  = if_addr;
      req_d.wdata = '0;
      en_d        = 1'b1;
    end

    if (done) begin
      en_d     = 1'b0;
      req_d.we = 1'b0;
      if (state_q == ARB_IF_BUSY) begin
        if_ready_d = 1'b1;
        if_rdata_d = mem_ack ? mem_rdata : ERR_RDATA;
      end else begin
        dm_ready_d = 1'b1;
        if (!req_q.we) begin
          dm_rdata_d = mem_ack ? mem_rdata : ERR_RDATA;
        end
      end
      if (timeout_hit) begin
        err_d = 1'b1;
      end
    end
  end

endmodule
